pc16_rstack: RTL and testbench

PC16_RSTACK -- requirements
Module: pc16_rstack

---
 rtl/pc16_rstack.sv | 132 +++++++++++++
 tb/tb_pc16_rstack.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc16_rstack.sv
// rtl/pc16_rstack.sv - 16-bit program counter with optional 4-deep return stack
// Return stack is built only when PC16_RSTACK_EN is defined; otherwise call acts as load.
module pc16_rstack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        inc,
    input  logic        clr,
    input  logic        call,
    input  logic        ret,
    output logic [15:0] out,
    output logic [2:0]  depth,
    output logic        ovf,
    output logic        unf
);

    logic [15:0] out_q;
    logic [15:0] out_d;
    logic [15:0] out_inc;

    assign out_inc = out_q + 16'd1;
    assign out     = out_q;

`ifdef PC16_RSTACK_EN
    logic [15:0] stk [4];
    logic [2:0]  depth_q;
    logic [2:0]  depth_d;
    logic        ovf_q;
    logic        ovf_d;
    logic        unf_q;
    logic        unf_d;
    logic        push;
    logic        pop;

    always_comb begin
        out_d   = out_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (clr) begin
            out_d   = 16'd0;
            depth_d = 3'd0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (ret) begin
            if (depth_q != 3'd0) begin
                out_d   = stk[0];
                depth_d = depth_q - 3'd1;
                pop     = 1'b1;
            end else begin
                out_d = out_inc;
                unf_d = 1'b1;
            end
        end else if (call) begin
            out_d = in;
            push  = 1'b1;
            if (depth_q == 3'd4) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + 3'd1;
            end
        end else if (load) begin
            out_d = in;
        end else if (inc) begin
            out_d = out_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= 16'd0;
            depth_q <= 3'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry 0 is the top; a push into a full stack shifts the oldest entry out of slot 3.
    always_ff @(posedge clk) begin
        if (push) begin
            stk[0] <= out_inc;
            for (int i = 1; i < 4; i++) begin
                stk[i] <= stk[i-1];
            end
        end else if (pop) begin
            for (int i = 0; i < 3; i++) begin
                stk[i] <= stk[i+1];
            end
        end
    end

    assign depth = depth_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
`else
    logic unused_ret;

    assign unused_ret = ret;

    always_comb begin
        out_d = out_q;
        if (clr) begin
            out_d = 16'd0;
        end else if (call || load) begin
            out_d = in;
        end else if (inc) begin
            out_d = out_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 16'd0;
        end else begin
            out_q <= out_d;
        end
    end

    assign depth = 3'd0;
    assign ovf   = 1'b0;
    assign unf   = 1'b0;
`endif

endmodule

// File: tb/tb_pc16_rstack.sv
// tb/tb_pc16_rstack.sv - randomized and directed bench for pc16_rstack against a queue-based model
module tb_pc16_rstack;

`ifdef PC16_RSTACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in = 16'd0;
    logic        load = 1'b0;
    logic        inc = 1'b0;
    logic        clr = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [15:0] out;
    logic [2:0]  depth;
    logic        ovf;
    logic        unf;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc;
    logic [15:0] m_st [$];
    logic        m_ovf;
    logic        m_unf;

    pc16_rstack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .load  (load),
        .inc   (inc),
        .clr   (clr),
        .call  (call),
        .ret   (ret),
        .out   (out),
        .depth (depth),
        .ovf   (ovf),
        .unf   (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = 16'd0;
        m_st  = {};
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Reference behaviour: queue back is top of stack, oldest entry at the front.
    task automatic model_step();
        if (clr) begin
            model_reset();
        end else if (ret && STACK_EN) begin
            if (m_st.size() > 0) begin
                m_pc = m_st.pop_back();
            end else begin
                m_unf = 1'b1;
                m_pc  = m_pc + 16'd1;
            end
        end else if (call) begin
            if (STACK_EN) begin
                if (m_st.size() == 4) begin
                    void'(m_st.pop_front());
                    m_ovf = 1'b1;
                end
                m_st.push_back(m_pc + 16'd1);
            end
            m_pc = in;
        end else if (load) begin
            m_pc = in;
        end else if (inc) begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".out"},   32'(out),   32'(m_pc));
        check({tag, ".depth"}, 32'(depth), 32'(m_st.size()));
        check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        check({tag, ".unf"},   32'(unf),   32'(m_unf));
    endtask

    task automatic step(input string tag, input logic c_clr, input logic c_ret, input logic c_call,
                        input logic c_load, input logic c_inc, input logic [15:0] din);
        @(negedge clk);
        clr  = c_clr;
        ret  = c_ret;
        call = c_call;
        load = c_load;
        inc  = c_inc;
        in   = din;
        @(posedge clk);
        #1;
        model_step();
        compare_model(tag);
        clr  = 1'b0;
        ret  = 1'b0;
        call = 1'b0;
        load = 1'b0;
        inc  = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check("reset.out", 32'(out), 32'h0);
        check("reset.depth", 32'(depth), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // count up and wrap
        for (int i = 0; i < 3; i++) step("inc", 0, 0, 0, 0, 1, 16'd0);
        check("inc3", 32'(out), 32'h3);
        step("load_ffff", 0, 0, 0, 1, 0, 16'hFFFF);
        step("wrap", 0, 0, 0, 0, 1, 16'd0);
        check("wrap0", 32'(out), 32'h0);
        check("wrap_noflag", 32'({ovf, unf}), 32'h0);

`ifdef PC16_RSTACK_EN
        step("load10", 0, 0, 0, 1, 0, 16'h0010);
        step("call100", 0, 0, 1, 0, 0, 16'h0100);
        check("call_out", 32'(out), 32'h0100);
        check("call_depth", 32'(depth), 32'h1);
        step("ret11", 0, 1, 0, 0, 0, 16'h0);
        check("ret_out", 32'(out), 32'h0011);
        check("ret_depth", 32'(depth), 32'h0);

        step("clr", 1, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) step("call5", 0, 0, 1, 0, 0, 16'(i + 1));
        check("ovf_depth", 32'(depth), 32'h4);
        check("ovf_flag", 32'(ovf), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step("ret4", 0, 1, 0, 0, 0, 16'h0);
            check("ret4_out", 32'(out), 32'(5 - i));
        end
        step("ret_unf", 0, 1, 0, 0, 0, 16'h0);
        check("unf_flag", 32'(unf), 32'h1);
        check("ovf_sticky", 32'(ovf), 32'h1);

        step("call_pre", 0, 0, 1, 0, 0, 16'h0777);
        step("all_cmds", 1, 1, 1, 1, 1, 16'hBEEF);
        check("all_out", 32'(out), 32'h0);
        check("all_state", 32'({depth, ovf, unf}), 32'h0);
        step("load_a", 0, 0, 0, 1, 0, 16'h0A00);
        step("call_a", 0, 0, 1, 0, 0, 16'h0B00);
        step("ret_call_load", 0, 1, 1, 1, 0, 16'h0C00);
        check("pop_only_out", 32'(out), 32'h0A01);
        check("pop_only_depth", 32'(depth), 32'h0);

        for (int i = 0; i < 3; i++) step("fill3", 0, 0, 1, 0, 0, 16'(16'h0200 + i));
        step("load1234", 0, 0, 0, 1, 0, 16'h1234);
        check("pre_rst_depth", 32'(depth), 32'h3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_out", 32'(out), 32'h0);
        check("async_depth", 32'(depth), 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        step("post_rst", 0, 0, 0, 0, 1, 16'h0);
        check("post_rst_out", 32'(out), 32'h1);
`else
        step("call42", 0, 0, 1, 0, 0, 16'h0042);
        check("nostk_call_out", 32'(out), 32'h0042);
        check("nostk_depth", 32'(depth), 32'h0);
        step("ret_inc", 0, 1, 0, 0, 1, 16'h0);
        check("nostk_retinc", 32'(out), 32'h0043);
        check("nostk_flags", 32'({ovf, unf}), 32'h0);
        step("ret_only", 0, 1, 0, 0, 0, 16'h0);
        check("nostk_hold", 32'(out), 32'h0043);
`endif

        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            step("rand", r < 3, (r >= 3 && r < 30) || (r % 11 == 0), (r >= 30 && r < 58) || (r % 7 == 0),
                 r >= 58 && r < 70, r >= 70 && r < 92, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
